// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx_if
//  Description : Bundle of the piso_tx load handshake, bit-rate strobe and
//                serial-side outputs.
//                  master : parallel producer / serial consumer side
//                  slave  : the transmitter itself
//                Signals:
//                  load_valid  producer has a word on load_data
//                  load_data   WIDTH-bit word to transmit
//                  load_ready  transmitter can accept a word this cycle
//                  bit_en      bit-rate strobe (tie high for one bit per clk)
//                  ser_out     serial data, registered
//                  ser_valid   ser_out carries a frame bit
//                  frame_start first bit of a frame is on ser_out
//                  done        one-clk pulse after the last bit of a frame
//  Revision    : 1.0  initial release
// ============================================================================
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             bit_en;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             done;

    modport master (
        output load_valid,
        output load_data,
        output bit_en,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  frame_start,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  bit_en,
        output load_ready,
        output ser_out,
        output ser_valid,
        output frame_start,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx
//  Description : Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word
//                over a valid/ready handshake and shifts it out one bit per
//                enabled cycle (bit_en) on a registered serial line.
//                Back-to-back words are chained with no idle cycle.
//  Parameters  : WIDTH      word width, 2..32
//                MSB_FIRST  1: bit WIDTH-1 first, 0: bit 0 first
//  Ports       : clk        sole clock, rising edge
//                rst_n      synchronous active-low reset
//                bus        piso_tx_if.slave (load handshake, bit_en,
//                           ser_out / ser_valid / frame_start / done)
//  Revision    : 1.0  initial release
// ============================================================================
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    piso_tx_if.slave  bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             ser_valid_reg;
    logic             frame_start_reg;
    logic             done_reg;

    logic [WIDTH-1:0] shreg_next;
    logic             head_bit;
    logic             cnt_zero;
    logic             load_ready_int;

    // The bit on the line is always the head of the shift register, so
    // ser_out is a flop output with no extra register. The register is
    // cleared whenever the block idles, which keeps ser_out low in IDLE.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shreg_next = {shreg[WIDTH-2:0], 1'b0};
            assign head_bit   = shreg[WIDTH-1];
        end else begin : g_lsb_first
            assign shreg_next = {1'b0, shreg[WIDTH-1:1]};
            assign head_bit   = shreg[0];
        end
    endgenerate

    assign cnt_zero = (cnt == '0);

    // Ready is a function of state and the strobe only; load_valid never
    // feeds back into it, so producers may wait on ready before raising valid.
    assign load_ready_int = (state == IDLE) |
                            ((state == SHIFT) & cnt_zero & bus.bit_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Any partial frame is dropped without a done pulse.
            state           <= IDLE;
            shreg           <= '0;
            cnt             <= '0;
            ser_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    // A load in IDLE does not wait for bit_en.
                    if (bus.load_valid) begin
                        shreg           <= bus.load_data;
                        cnt             <= CNT_LAST;
                        ser_valid_reg   <= 1'b1;
                        frame_start_reg <= 1'b1;
                        state           <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Without bit_en everything holds, frame_start included,
                    // so the first bit keeps its marker for its full length.
                    if (bus.bit_en) begin
                        if (!cnt_zero) begin
                            shreg           <= shreg_next;
                            cnt             <= cnt - CNT_ONE;
                            frame_start_reg <= 1'b0;
                        end else begin
                            done_reg <= 1'b1;
                            if (bus.load_valid) begin
                                // Chain the next word onto this edge.
                                shreg           <= bus.load_data;
                                cnt             <= CNT_LAST;
                                frame_start_reg <= 1'b1;
                            end else begin
                                shreg           <= '0;
                                ser_valid_reg   <= 1'b0;
                                frame_start_reg <= 1'b0;
                                state           <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state           <= IDLE;
                    shreg           <= '0;
                    cnt             <= '0;
                    ser_valid_reg   <= 1'b0;
                    frame_start_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready  = load_ready_int;
    assign bus.ser_out     = head_bit;
    assign bus.ser_valid   = ser_valid_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.done        = done_reg;

endmodule
`default_nettype wire
